// File: rtl/nes_mem_pkg.sv
// Shared types for the NES memory-port glue: arbiter states and the loader write record.
package nes_mem_pkg;

    localparam int NES_ADDR_W = 22;

    typedef enum logic [2:0] {BOOT, LOAD, DRAIN, HOLD, RUN} arb_state_t;

    typedef struct packed {
        logic [NES_ADDR_W-1:0] addr;
        logic [7:0]            data;
    } ld_wr_t;

endpackage

// File: rtl/sync_fifo_small.sv
// Small synchronous FIFO with register storage; push while full is accepted only alongside a pop.
module sync_fifo_small #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sdram_load_arbiter.sv
// SDRAM port A owner: loader writes are slotted onto nes_ce, the CPU gets the port after the
// FIFO drains, and reset_nes brackets the whole download plus a fixed settling window.
module sdram_load_arbiter
    import nes_mem_pkg::*;
#(
    parameter int FIFO_DEPTH        = 4,
    parameter int ISSUE_PHASE       = 3,
    parameter int POST_RESET_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [1:0]            nes_ce,
    input  logic                  sys_reset,
    input  logic                  load_done,
    input  logic                  ld_wr,
    input  logic [NES_ADDR_W-1:0] ld_addr,
    input  logic [7:0]            ld_data,
    input  logic [NES_ADDR_W-1:0] cpu_addr,
    input  logic                  cpu_wr,
    input  logic [7:0]            cpu_dout,
    output logic [NES_ADDR_W-1:0] mem_addr,
    output logic                  mem_we,
    output logic [7:0]            mem_din,
    output logic                  reset_nes,
    output logic                  loader_owns,
    output logic                  overflow
);
    arb_state_t  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    ld_wr_t      slot_q, slot_d;
    logic        slot_we_q, slot_we_d;
    logic        load_done_q;
    logic        reset_nes_q, reset_nes_d;
    logic        overflow_q, overflow_d;

    ld_wr_t      push_ent, head;
    logic        fifo_full, fifo_empty, pop, issue, owns, done_fall;

    assign owns      = (state_q == BOOT) || (state_q == LOAD) || (state_q == DRAIN);
    assign issue     = owns && (nes_ce == 2'(ISSUE_PHASE));
    assign pop       = issue && !fifo_empty;
    assign done_fall = load_done_q && !load_done;

    always_comb begin
        push_ent      = '0;
        push_ent.addr = ld_addr;
        push_ent.data = ld_data;
    end

    sync_fifo_small #(
        .WIDTH($bits(ld_wr_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(resetn),
        .push (ld_wr),
        .din  (push_ent),
        .pop  (pop),
        .dout (head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        slot_d     = slot_q;
        slot_we_d  = slot_we_q;
        overflow_d = overflow_q;

        // A slot is replaced only on the issue clk, so every slot lasts a full nes_ce period.
        if (issue) begin
            slot_we_d = !fifo_empty;
            if (!fifo_empty) slot_d = head;
        end

        unique case (state_q)
            BOOT:  if (ld_wr) state_d = LOAD;
            LOAD:  if (load_done) state_d = DRAIN;
            DRAIN: begin
                // An active slot finishes exactly on the next issue clk.
                if (fifo_empty && (!slot_we_q || issue)) begin
                    state_d = HOLD;
                    cnt_d   = 16'(POST_RESET_CYCLES);
                end
            end
            HOLD: begin
                if (done_fall)        state_d = LOAD;
                else if (cnt_q == 16'd1) state_d = RUN;
                else                  cnt_d = cnt_q - 16'd1;
            end
            RUN: begin
                if (done_fall) begin
                    state_d    = LOAD;
                    overflow_d = 1'b0;
                end
            end
            default: state_d = BOOT;
        endcase

        if (ld_wr && fifo_full && !pop) overflow_d = 1'b1;

        reset_nes_d = (state_d != RUN) || sys_reset;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= BOOT;
            cnt_q       <= '0;
            slot_q      <= '0;
            slot_we_q   <= 1'b0;
            load_done_q <= 1'b0;
            reset_nes_q <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            slot_we_q   <= slot_we_d;
            load_done_q <= load_done;
            reset_nes_q <= reset_nes_d;
            overflow_q  <= overflow_d;
        end
    end

    assign mem_addr    = owns ? slot_q.addr : cpu_addr;
    assign mem_we      = owns ? slot_we_q   : cpu_wr;
    assign mem_din     = owns ? slot_q.data : cpu_dout;
    assign reset_nes   = reset_nes_q;
    assign loader_owns = owns;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_sdram_load_arbiter.sv
// Directed bench: loader slotting, overflow, drain/handover, run-time pass-through, reload, async reset.
module tb_sdram_load_arbiter;
    import nes_mem_pkg::*;

    logic        clk = 1'b0;
    logic        resetn, sys_reset, load_done, ld_wr, cpu_wr;
    logic [1:0]  nes_ce, edge_ce;
    logic [21:0] ld_addr, cpu_addr;
    logic [7:0]  ld_data, cpu_dout;
    logic [21:0] mem_addr;
    logic        mem_we, reset_nes, loader_owns, overflow;
    logic [7:0]  mem_din;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        sys_rst;
        logic [21:0] addr;
        logic        wr;
        logic [7:0]  dout;
        logic [21:0] e_addr;
        logic        e_we;
        logic [7:0]  e_din;
        logic        e_rst;
    } vec_t;
    vec_t vt[5];

    sdram_load_arbiter dut (
        .clk(clk), .resetn(resetn), .nes_ce(nes_ce), .sys_reset(sys_reset),
        .load_done(load_done), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data),
        .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
        .reset_nes(reset_nes), .loader_owns(loader_owns), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One clock: sample point is 1ns after the edge; edge_ce is the phase the DUT just saw.
    task automatic cyc();
        @(posedge clk);
        #1;
        edge_ce = nes_ce;
        nes_ce  = nes_ce + 2'd1;
        ld_wr   = 1'b0;
    endtask

    task automatic wait_ce(input logic [1:0] v);
        for (int i = 0; i < 8 && nes_ce != v; i++) cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int         nw, handover, hold;
        logic       prev_we;
        logic [6:0] sb_we;

        vt[0] = '{1'b0, 22'h000600, 1'b1, 8'h5A, 22'h000600, 1'b1, 8'h5A, 1'b0};
        vt[1] = '{1'b0, 22'h3FFFFF, 1'b0, 8'hFF, 22'h3FFFFF, 1'b0, 8'hFF, 1'b0};
        vt[2] = '{1'b1, 22'h123456, 1'b1, 8'h00, 22'h123456, 1'b1, 8'h00, 1'b1};
        vt[3] = '{1'b0, 22'h000000, 1'b1, 8'h81, 22'h000000, 1'b1, 8'h81, 1'b0};
        vt[4] = '{1'b0, 22'h2AAAAA, 1'b1, 8'h55, 22'h2AAAAA, 1'b1, 8'h55, 1'b0};

        resetn = 1'b1; nes_ce = 2'd0; edge_ce = 2'd0; sys_reset = 1'b0; load_done = 1'b0;
        ld_wr = 1'b0; ld_addr = '0; ld_data = '0; cpu_addr = '0; cpu_wr = 1'b0; cpu_dout = '0;

        // Reset state
        #2 resetn = 1'b0;
        #1;
        chk("rst.mem_we", mem_we, 1'b0);
        chk("rst.mem_addr", mem_addr, 22'h0);
        chk("rst.mem_din", mem_din, 8'h0);
        chk("rst.reset_nes", reset_nes, 1'b1);
        chk("rst.loader_owns", loader_owns, 1'b1);
        chk("rst.overflow", overflow, 1'b0);
        cyc(); cyc();
        chk("rst.hold_we", mem_we, 1'b0);
        resetn = 1'b1;

        // Single byte pushed on phase 1: visible after the phase-3 edge for 4 clks
        wait_ce(2'd1);
        ld_wr = 1'b1; ld_addr = 22'h000010; ld_data = 8'hA5;
        sb_we = 7'b0111100;
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("single.we", mem_we, sb_we[i]);
            if (sb_we[i]) begin
                chk("single.addr", mem_addr, 22'h000010);
                chk("single.din", mem_din, 8'hA5);
            end
            chk("single.reset_nes", reset_nes, 1'b1);
        end
        chk("single.overflow", overflow, 1'b0);

        // Burst of 6 on consecutive clks starting at phase 0: one pop lands mid-burst, 6th dropped
        wait_ce(2'd0);
        nw = 0;
        for (int k = 0; k < 40; k++) begin
            if (k < 6) begin
                ld_wr = 1'b1; ld_addr = 22'(32'h100 + k); ld_data = 8'(32'h10 + k);
            end
            cyc();
            if (edge_ce == 2'd3 && mem_we) begin
                chk("burst.addr", mem_addr, 32'h100 + nw);
                chk("burst.din", mem_din, 32'h10 + nw);
                nw++;
            end
        end
        chk("burst.count", nw, 5);
        chk("burst.overflow", overflow, 1'b1);

        // Drain and handover: 3 queued bytes, ownership moves on the edge after the 3rd slot ends
        wait_ce(2'd0);
        nw = 0; handover = -1; prev_we = 1'b0;
        for (int k = 0; k < 40 && handover < 0; k++) begin
            if (k < 3) begin
                ld_wr = 1'b1; ld_addr = 22'(32'h200 + k); ld_data = 8'(32'hC0 + k);
            end
            if (k == 3) load_done = 1'b1;
            cyc();
            if (!loader_owns) handover = k;
            else begin
                prev_we = mem_we;
                if (edge_ce == 2'd3 && mem_we) begin
                    chk("drain.addr", mem_addr, 32'h200 + nw);
                    chk("drain.din", mem_din, 32'hC0 + nw);
                    nw++;
                end
            end
        end
        chk("drain.handover_clk", handover, 15);
        chk("drain.count", nw, 3);
        chk("drain.last_slot_full", prev_we, 1'b1);
        chk("drain.mem_we_cpu", mem_we, 1'b0);

        hold = 0;
        for (int i = 0; i < 400 && reset_nes; i++) begin
            hold++;
            cyc();
        end
        chk("hold.cycles", hold, 255);
        chk("run.reset_nes", reset_nes, 1'b0);
        chk("run.loader_owns", loader_owns, 1'b0);

        cpu_addr = 22'h000600; cpu_wr = 1'b1; cpu_dout = 8'h3C;
        #1;
        chk("run.comb_addr", mem_addr, 22'h000600);
        chk("run.comb_we", mem_we, 1'b1);
        chk("run.comb_din", mem_din, 8'h3C);

        // Table: CPU pass-through and registered sys_reset in RUN
        for (int i = 0; i < 5; i++) begin
            sys_reset = vt[i].sys_rst; cpu_addr = vt[i].addr; cpu_wr = vt[i].wr; cpu_dout = vt[i].dout;
            cyc();
            chk("vec.mem_addr", mem_addr, vt[i].e_addr);
            chk("vec.mem_we", mem_we, vt[i].e_we);
            chk("vec.mem_din", mem_din, vt[i].e_din);
            chk("vec.reset_nes", reset_nes, vt[i].e_rst);
        end
        sys_reset = 1'b0; cpu_addr = '0; cpu_wr = 1'b0; cpu_dout = '0;
        cyc();

        // sys_reset pulse of 10 clks
        sys_reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("sysrst.reset_nes", reset_nes, 1'b1);
            chk("sysrst.owns", loader_owns, 1'b0);
        end
        sys_reset = 1'b0;
        cyc();
        chk("sysrst.release", reset_nes, 1'b0);
        chk("sysrst.state_run", loader_owns, 1'b0);
        chk("run.overflow_sticky", overflow, 1'b1);

        // Reload
        load_done = 1'b0;
        cyc();
        chk("reload.owns", loader_owns, 1'b1);
        chk("reload.reset_nes", reset_nes, 1'b1);
        chk("reload.overflow", overflow, 1'b0);

        // Async reset in the middle of a slot, with bytes still queued
        for (int i = 0; i < 3; i++) begin
            ld_wr = 1'b1; ld_addr = 22'(32'h300 + i); ld_data = 8'(32'h70 + i);
            cyc();
        end
        for (int i = 0; i < 12 && !mem_we; i++) cyc();
        chk("areset.slot_active", mem_we, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("areset.we", mem_we, 1'b0);
        chk("areset.owns", loader_owns, 1'b1);
        chk("areset.reset_nes", reset_nes, 1'b1);
        cyc();
        resetn = 1'b1;
        load_done = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            chk("areset.fifo_empty", mem_we, 1'b0);
            chk("areset.boot", loader_owns, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
